// File: rtl/databus_arbiter.sv
// databus_arbiter: 4-requester round-robin bus arbiter with a per-owner hold limit.
// Define DBUS_ARB_PRIO0_EN to give requester 0 absolute priority. Requester 0 then
// preempts any other owner and is exempt from the hold limit.
// Without DBUS_ARB_PRIO0_EN the arbiter is pure round-robin.
module databus_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [3:0] reg_in0,
  input  logic [3:0] reg_in1,
  input  logic [3:0] reg_in2,
  input  logic [3:0] reg_in3,
  output logic [3:0] grant,
  output logic [1:0] select_source,
  output logic       bus_valid,
  output logic [3:0] databus
);

  localparam int unsigned NREQ  = 4;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_SAT   = {CNT_W{1'b1}};

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   hold_q, hold_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   rel_ptr;

  // First set request bit searching p, p+1, ... mod 4 (caller guarantees r != 0)
  function automatic logic [IDX_W-1:0] rr_pick(input logic [IDX_W-1:0] p,
                                               input logic [NREQ-1:0] r);
    logic [IDX_W-1:0] idx;
    logic             found;
    rr_pick = p;
    found   = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = p + IDX_W'(k);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  // Winner of a fresh arbitration from pointer p
  function automatic logic [IDX_W-1:0] arb_pick(input logic [IDX_W-1:0] p,
                                                input logic [NREQ-1:0] r);
`ifdef DBUS_ARB_PRIO0_EN
    arb_pick = r[0] ? IDX_W'(0) : rr_pick(p, r);
`else
    arb_pick = rr_pick(p, r);
`endif
  endfunction

  // Next-state and registered-output computation
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    hold_d  = hold_q;
    ptr_d   = ptr_q;
    rel_ptr = sel_q + IDX_W'(1);

    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          sel_d   = arb_pick(ptr_q, req);
          hold_d  = CNT_W'(1);
        end
      end
      GRANT: begin
`ifdef DBUS_ARB_PRIO0_EN
        if (sel_q != IDX_W'(0) && req[0]) begin
          sel_d  = IDX_W'(0);
          hold_d = CNT_W'(1);
          ptr_d  = rel_ptr;
        end else if (sel_q == IDX_W'(0) && req[0]) begin
          hold_d = (hold_q == HOLD_SAT) ? hold_q : hold_q + CNT_W'(1);
        end else
`endif
        if (req[sel_q] && hold_q < HOLD_LIMIT) begin
          hold_d = hold_q + CNT_W'(1);
        end else begin
          ptr_d = rel_ptr;
          if (|req) begin
            sel_d  = arb_pick(rel_ptr, req);
            hold_d = CNT_W'(1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    grant_d = (state_d == GRANT) ? (NREQ'(1) << sel_d) : '0;
    valid_d = (state_d == GRANT);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      hold_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      hold_q  <= hold_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant         = grant_q;
  assign select_source = sel_q;
  assign bus_valid     = valid_q;

  // Shared bus mux, forced to zero while nobody owns the bus
  always_comb begin
    databus = '0;
    if (valid_q) begin
      case (sel_q)
        2'd0:    databus = reg_in0;
        2'd1:    databus = reg_in1;
        2'd2:    databus = reg_in2;
        default: databus = reg_in3;
      endcase
    end
  end

endmodule

// File: tb/tb_databus_arbiter.sv
// Self-checking bench for databus_arbiter: directed scenarios plus random traffic,
// all checked against an integer-level arbitration model.
module tb_databus_arbiter;

  localparam int MAXH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] r0, r1, r2, r3;
  logic [3:0] grant;
  logic [1:0] select_source;
  logic       bus_valid;
  logic [3:0] databus;

  int n_tests = 0;
  int n_fail  = 0;

  // model state: owner -1 means bus idle
  int m_owner = -1;
  int m_hold  = 0;
  int m_ptr   = 0;
  int m_sel   = 0;

  databus_arbiter #(.MAX_HOLD(MAXH)) dut (
    .clk(clk), .reset(reset), .req(req),
    .reg_in0(r0), .reg_in1(r1), .reg_in2(r2), .reg_in3(r3),
    .grant(grant), .select_source(select_source),
    .bus_valid(bus_valid), .databus(databus)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] reg_of(input int i);
    case (i)
      0: return r0;
      1: return r1;
      2: return r2;
      default: return r3;
    endcase
  endfunction

  function automatic int pick(input int p, input logic [3:0] r);
`ifdef DBUS_ARB_PRIO0_EN
    if (r[0]) return 0;
`endif
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  // Advance the model by one rising edge using the current inputs
  task automatic model_edge();
    if (reset) begin
      m_owner = -1; m_sel = 0; m_hold = 0; m_ptr = 0;
      return;
    end
    if (m_owner < 0) begin
      if (req != 4'b0) begin
        m_owner = pick(m_ptr, req); m_hold = 1; m_sel = m_owner;
      end
      return;
    end
`ifdef DBUS_ARB_PRIO0_EN
    if (m_owner != 0 && req[0]) begin
      m_ptr = (m_owner + 1) % 4; m_owner = 0; m_sel = 0; m_hold = 1;
      return;
    end
    if (m_owner == 0 && req[0]) begin
      if (m_hold < 15) m_hold++;
      return;
    end
`endif
    if (req[m_owner] && m_hold < MAXH) begin
      m_hold++;
    end else begin
      m_ptr = (m_owner + 1) % 4;
      if (req != 4'b0) begin
        m_owner = pick(m_ptr, req); m_hold = 1; m_sel = m_owner;
      end else begin
        m_owner = -1;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare all DUT outputs against the model
  task automatic compare_model();
    int eg, ev, ed;
    eg = (m_owner >= 0) ? (1 << m_owner) : 0;
    ev = (m_owner >= 0) ? 1 : 0;
    ed = (m_owner >= 0) ? int'(reg_of(m_sel)) : 0;
    chk("grant", int'(grant), eg);
    chk("select_source", int'(select_source), m_sel);
    chk("bus_valid", int'(bus_valid), ev);
    chk("databus", int'(databus), ed);
  endtask

  // One clock: predict, clock, sample 1ns after the edge, compare
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    reset = 1'b1; req = 4'b0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req = 4'b0;
    r0 = 4'h0; r1 = 4'h1; r2 = 4'h2; r3 = 4'h3;
    @(negedge clk);

    // reset state
    do_reset();
    chk("rst_grant", int'(grant), 0);
    chk("rst_sel", int'(select_source), 0);
    chk("rst_valid", int'(bus_valid), 0);
    chk("rst_databus", int'(databus), 0);

    // single requester 1, re-granted every MAX_HOLD cycles with no gap
    r1 = 4'hA; req = 4'b0010;
    step();
    chk("single_grant", int'(grant), 4'b0010);
    chk("single_sel", int'(select_source), 1);
    chk("single_bus", int'(databus), 4'hA);
    for (int i = 0; i < 9; i++) begin
      step();
      chk("single_hold", int'(grant), 4'b0010);
    end

    // all requesting: 0,1,2,3,0 each for MAX_HOLD cycles
    do_reset();
    r0 = 4'h0; r1 = 4'h1; r2 = 4'h2; r3 = 4'h3; req = 4'b1111;
    for (int i = 0; i < 4 * MAXH + 1; i++) begin
      step();
`ifndef DBUS_ARB_PRIO0_EN
      chk("rr_order", int'(select_source), (i / MAXH) % 4);
      chk("rr_bus", int'(databus), (i / MAXH) % 4);
`endif
    end

    // early release of owner 2 to owner 3, then idle
    do_reset();
    req = 4'b1100;
    step(); step();
    chk("early_own2", int'(grant), 4'b0100);
    req = 4'b1000;
    step();
    chk("early_own3", int'(grant), 4'b1000);
    req = 4'b0000;
    step();
    chk("early_idle_valid", int'(bus_valid), 0);
    chk("early_idle_bus", int'(databus), 0);
    chk("early_idle_sel", int'(select_source), 3);

    // reset during owner 3's second cycle, then search restarts at 0
    do_reset();
    req = 4'b1000;
    step(); step();
    reset = 1'b1;
    step();
    chk("midrst_grant", int'(grant), 0);
    chk("midrst_sel", int'(select_source), 0);
    reset = 1'b0; req = 4'b1111;
    step();
    chk("midrst_first", int'(grant), 4'b0001);

    // requester 1 owns, then req[0] rises
    do_reset();
    req = 4'b0010;
    step();
    req = 4'b0011;
`ifdef DBUS_ARB_PRIO0_EN
    step();
    chk("prio_preempt", int'(grant), 4'b0001);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("prio_hold", int'(grant), 4'b0001);
    end
`else
    for (int i = 0; i < MAXH - 1; i++) begin
      step();
      chk("rr_keep1", int'(grant), 4'b0010);
    end
    step();
    chk("rr_release1", int'(grant), 4'b0001);
`endif

    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) != 0) req = 4'($urandom);
      r0 = 4'($urandom); r1 = 4'($urandom); r2 = 4'($urandom); r3 = 4'($urandom);
      step();
      n_tests++;
      if (grant != 4'b0 && (grant & (grant - 4'd1)) != 4'b0) begin
        n_fail++;
        $display("FAIL onehot: grant=%b", grant);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
